// File: rtl/regfile_if.sv
// Bundle of read, write and clear signals for multiport_register_file.
// dbg_clr_state mirrors the clear FSM state (0 = IDLE, 1 = CLEAR) for observation.
interface regfile_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic              rd_en_a;
  logic              rd_en_b;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_drop;
  logic              clr_req;
  logic              clr_busy;
  logic              clr_done;
  logic              dbg_clr_state;

  // Handshake: there is no ready; a read issued with rd_en_x at an edge is valid on
  // rd_data_x after that edge; a write is accepted unless clr_busy, in which case
  // wr_drop pulses the following cycle.
  modport master (
    output rd_en_a, rd_en_b, rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, clr_req,
    input  rd_data_a, rd_data_b, wr_drop, clr_busy, clr_done, dbg_clr_state
  );

  modport slave (
    input  rd_en_a, rd_en_b, rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, clr_req,
    output rd_data_a, rd_data_b, wr_drop, clr_busy, clr_done, dbg_clr_state
  );
endinterface

// File: rtl/multiport_register_file.sv
// Two-read / one-write register file with a sequential bulk-clear FSM.
// Optional macro REGFILE_BYPASS_EN selects write-first same-cycle reads (default read-first).
module multiport_register_file #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0
) (
  input  logic     clk,
  input  logic     rst,
  regfile_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data_a;
  logic [DATA_W-1:0] r_rd_data_b;
  logic              r_wr_drop;
  logic              r_clr_busy;
  logic              r_clr_done;

  logic              w_wr_ok;
  logic [DATA_W-1:0] w_rd_a;
  logic [DATA_W-1:0] w_rd_b;

  // A write lands only in IDLE, and never on the hardwired zero register.
  assign w_wr_ok = bus.wr_en && (r_state == IDLE) &&
                   !((ZERO_REG != 0) && (bus.wr_addr == '0));

  always_comb begin
    w_rd_a = r_mem[bus.rd_addr_a];
`ifdef REGFILE_BYPASS_EN
    if (w_wr_ok && (bus.wr_addr == bus.rd_addr_a)) w_rd_a = bus.wr_data;
`endif
    if ((ZERO_REG != 0) && (bus.rd_addr_a == '0)) w_rd_a = '0;
  end

  always_comb begin
    w_rd_b = r_mem[bus.rd_addr_b];
`ifdef REGFILE_BYPASS_EN
    if (w_wr_ok && (bus.wr_addr == bus.rd_addr_b)) w_rd_b = bus.wr_data;
`endif
    if ((ZERO_REG != 0) && (bus.rd_addr_b == '0)) w_rd_b = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_clr_cnt   <= '0;
      r_rd_data_a <= '0;
      r_rd_data_b <= '0;
      r_wr_drop   <= 1'b0;
      r_clr_busy  <= 1'b0;
      r_clr_done  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_wr_drop  <= 1'b0;
      r_clr_done <= 1'b0;
      if (bus.rd_en_a) r_rd_data_a <= w_rd_a;
      if (bus.rd_en_b) r_rd_data_b <= w_rd_b;
      case (r_state)
        IDLE: begin
          if (w_wr_ok) r_mem[bus.wr_addr] <= bus.wr_data;
          if (bus.clr_req) begin
            r_state    <= CLEAR;
            r_clr_busy <= 1'b1;
            r_clr_cnt  <= '0;
          end
        end
        CLEAR: begin
          // One entry per cycle; writes arriving now are discarded and flagged.
          r_mem[r_clr_cnt] <= '0;
          r_wr_drop        <= bus.wr_en;
          if (r_clr_cnt == ADDR_W'(DEPTH - 1)) begin
            r_state    <= IDLE;
            r_clr_busy <= 1'b0;
            r_clr_done <= 1'b1;
            r_clr_cnt  <= '0;
          end else begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.rd_data_a     = r_rd_data_a;
  assign bus.rd_data_b     = r_rd_data_b;
  assign bus.wr_drop       = r_wr_drop;
  assign bus.clr_busy      = r_clr_busy;
  assign bus.clr_done      = r_clr_done;
  assign bus.dbg_clr_state = r_state;
endmodule

// File: tb/tb_multiport_register_file.sv
// Scoreboard bench for multiport_register_file: a cycle-indexed reference model pushes
// expected read data and status per edge; a negedge monitor pops and compares.
module tb_multiport_register_file;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  regfile_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
  regfile_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) zbus ();

  multiport_register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(0)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  multiport_register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1)) u_dut_z (
    .clk (clk),
    .rst (rst),
    .bus (zbus.slave)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [DATA_W-1:0] exp_a_q[$];
  logic [DATA_W-1:0] exp_b_q[$];
  logic [2:0]        exp_ctl_q[$];   // {wr_drop, clr_busy, clr_done}
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: register contents plus the edge number at which a clear was accepted.
  logic [DATA_W-1:0] m_mem [DEPTH];
  int edge_n    = 0;
  int clr_start = -1;

  logic drv_active = 1'b0;
  logic mon_ctl = 1'b0, mon_a = 1'b0, mon_b = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    clr_start = -1;
  endtask

  // Drive one cycle's inputs (called at posedge+1) and record the expected response.
  task automatic drive(input logic ra, input logic [ADDR_W-1:0] aa,
                       input logic rb, input logic [ADDR_W-1:0] ab,
                       input logic we, input logic [ADDR_W-1:0] wa,
                       input logic [DATA_W-1:0] wd, input logic cr);
    int k;
    logic busy_now, busy_after, done_after, drop_after;
    logic [DATA_W-1:0] ea, eb;
    bus.rd_en_a = ra; bus.rd_addr_a = aa;
    bus.rd_en_b = rb; bus.rd_addr_b = ab;
    bus.wr_en = we; bus.wr_addr = wa; bus.wr_data = wd;
    bus.clr_req = cr;
    drv_active = 1'b1;
    k = edge_n - clr_start;
    busy_now = (clr_start >= 0) && (k >= 1) && (k <= DEPTH);
    ea = m_mem[aa];
    eb = m_mem[ab];
`ifdef REGFILE_BYPASS_EN
    if (!busy_now && we) begin
      if (wa == aa) ea = wd;
      if (wa == ab) eb = wd;
    end
`endif
    if (ra) exp_a_q.push_back(ea);
    if (rb) exp_b_q.push_back(eb);
    drop_after = busy_now && we;
    done_after = busy_now && (k == DEPTH);
    if (busy_now) m_mem[k-1] = '0;
    else if (we)  m_mem[wa]  = wd;
    if (!busy_now && cr) clr_start = edge_n;
    k = edge_n - clr_start;
    busy_after = (clr_start >= 0) && (k >= 0) && (k < DEPTH);
    exp_ctl_q.push_back({drop_after, busy_after, done_after});
    edge_n++;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, '0, 0);
  endtask

  task automatic fill_all();
    for (int i = 0; i < DEPTH; i++)
      drive(0, 0, 0, 0, 1, ADDR_W'(i), DATA_W'($urandom_range(1, 16'hFFFF)), 0);
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++)
      drive(1, ADDR_W'(i), 1, ADDR_W'(DEPTH - 1 - i), 0, 0, '0, 0);
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    mon_ctl <= drv_active;
    mon_a   <= drv_active & bus.rd_en_a;
    mon_b   <= drv_active & bus.rd_en_b;
  end

  always @(negedge clk) begin
    if (mon_ctl) begin
      if (exp_ctl_q.size() == 0) chk("ctl_queue_empty", 1, 0);
      else chk("ctl{drop,busy,done}", {29'd0, bus.wr_drop, bus.clr_busy, bus.clr_done},
               {29'd0, exp_ctl_q.pop_front()});
    end
    if (mon_a) begin
      if (exp_a_q.size() == 0) chk("rd_a_queue_empty", 1, 0);
      else chk("rd_data_a", {16'd0, bus.rd_data_a}, {16'd0, exp_a_q.pop_front()});
    end
    if (mon_b) begin
      if (exp_b_q.size() == 0) chk("rd_b_queue_empty", 1, 0);
      else chk("rd_data_b", {16'd0, bus.rd_data_b}, {16'd0, exp_b_q.pop_front()});
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.rd_en_a = 0; bus.rd_en_b = 0; bus.rd_addr_a = 0; bus.rd_addr_b = 0;
    bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0; bus.clr_req = 0;
    zbus.rd_en_a = 0; zbus.rd_en_b = 0; zbus.rd_addr_a = 0; zbus.rd_addr_b = 0;
    zbus.wr_en = 0; zbus.wr_addr = 0; zbus.wr_data = 0; zbus.clr_req = 0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    chk("reset_rd_data_a", {16'd0, bus.rd_data_a}, 0);
    chk("reset_rd_data_b", {16'd0, bus.rd_data_b}, 0);
    chk("reset_ctl", {29'd0, bus.wr_drop, bus.clr_busy, bus.clr_done}, 0);
    rst = 1'b0;

    // First write right after release, then read it one cycle later.
    drive(0, 0, 0, 0, 1, 3'd3, 16'hA5A5, 0);
    drive(1, 3'd3, 0, 0, 0, 0, '0, 0);
    // Same-cycle read/write on address 5 holding zero.
    drive(0, 0, 0, 0, 1, 3'd5, 16'h0000, 0);
    drive(0, 0, 1, 3'd5, 1, 3'd5, 16'h1234, 0);
    drive(1, 3'd5, 1, 3'd5, 0, 0, '0, 0);

    // Full clear with a write attempted during it.
    fill_all();
    read_all();
    drive(1, 3'd2, 0, 0, 0, 0, '0, 1);
    drive(0, 0, 1, 3'd2, 1, 3'd2, 16'hFFFF, 0);
    idle(9);
    read_all();

    // Randomised traffic with occasional clears.
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 1), ADDR_W'($urandom_range(0, DEPTH - 1)),
            $urandom_range(0, 1), ADDR_W'($urandom_range(0, DEPTH - 1)),
            $urandom_range(0, 1), ADDR_W'($urandom_range(0, DEPTH - 1)),
            DATA_W'($urandom_range(0, 16'hFFFF)), ($urandom_range(0, 29) == 0));

    // Reset in the middle of a clear.
    idle(10);
    fill_all();
    drive(0, 0, 0, 0, 0, 0, '0, 1);
    idle(4);
    drv_active = 1'b0;
    bus.rd_en_a = 0; bus.rd_en_b = 0; bus.wr_en = 0; bus.clr_req = 0;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midclr_rst_busy", {31'd0, bus.clr_busy}, 0);
    chk("midclr_rst_done", {31'd0, bus.clr_done}, 0);
    chk("midclr_rst_rd_a", {16'd0, bus.rd_data_a}, 0);
    @(posedge clk); #1;
    chk("midclr_rst_no_done", {31'd0, bus.clr_done}, 0);
    rst = 1'b0;
    model_reset();
    read_all();
    idle(10);
    drv_active = 1'b0;
    @(negedge clk);

    // Hardwired-zero instance.
    @(posedge clk); #1;
    zbus.wr_en = 1; zbus.wr_addr = 0; zbus.wr_data = 16'hBEEF;
    zbus.rd_en_a = 1; zbus.rd_addr_a = 0;
    @(posedge clk); #1;
    chk("z_same_cycle_rd_a", {16'd0, zbus.rd_data_a}, 0);
    chk("z_wr_drop_0", {31'd0, zbus.wr_drop}, 0);
    zbus.wr_addr = 3'd1; zbus.wr_data = 16'h1111;
    zbus.rd_en_b = 1; zbus.rd_addr_b = 0;
    @(posedge clk); #1;
    chk("z_rd_a_addr0", {16'd0, zbus.rd_data_a}, 0);
    chk("z_rd_b_addr0", {16'd0, zbus.rd_data_b}, 0);
    chk("z_wr_drop_1", {31'd0, zbus.wr_drop}, 0);
    zbus.wr_en = 0; zbus.rd_addr_a = 3'd1;
    @(posedge clk); #1;
    chk("z_rd_a_addr1", {16'd0, zbus.rd_data_a}, 32'h1111);
    chk("z_rd_b_addr0_again", {16'd0, zbus.rd_data_b}, 0);
    zbus.rd_en_a = 0; zbus.rd_en_b = 0;

    @(posedge clk); @(negedge clk);
    chk("ctl_queue_drained", exp_ctl_q.size(), 0);
    chk("rd_a_queue_drained", exp_a_q.size(), 0);
    chk("rd_b_queue_drained", exp_b_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
